// File: rtl/seq_add32_pkg.sv
// Shared types and constants for the byte-serial 32-bit adder.
package seq_add32_pkg;

  localparam int BYTE_W     = 8;
  localparam int NBYTES_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/byte_adder.sv
// 8-bit ripple-carry adder slice built from per-bit full adders.
module byte_adder
  import seq_add32_pkg::*;
(
  input  logic [BYTE_W-1:0] i_a,
  input  logic [BYTE_W-1:0] i_b,
  input  logic              i_cin,
  output logic [BYTE_W-1:0] o_sum,
  output logic              o_cout
);

  logic [BYTE_W:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < BYTE_W; i++) begin : g_bit
    assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_cout = w_c[BYTE_W];

endmodule

// File: rtl/seq_add32.sv
// Byte-serial adder: one shared byte slice processes one byte per clock,
// result held in DONE until the consumer takes it.
module seq_add32
  import seq_add32_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic [BYTE_W*NBYTES-1:0] b,
  input  logic                     cin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BYTE_W*NBYTES-1:0] sum,
  output logic                     cout,
  output logic                     ovf,
  output logic                     busy
);

  localparam int W     = BYTE_W * NBYTES;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_e            r_state;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic [W-1:0]      r_sum;
  logic              r_carry;
  logic [IDX_W-1:0]  r_idx;
  logic              r_cout;
  logic              r_ovf;
  logic              r_out_valid;

  logic [BYTE_W-1:0] w_a_byte;
  logic [BYTE_W-1:0] w_b_byte;
  logic [BYTE_W-1:0] w_slice_sum;
  logic              w_slice_cout;
  logic              w_last;
  logic              w_accept;

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign w_accept  = in_valid & in_ready;
  assign w_last    = (r_idx == IDX_W'(NBYTES - 1));
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

  // NOTE: every always_comb output gets a default before the mux so no latch is inferred.
  always_comb begin
    w_a_byte = '0;
    w_b_byte = '0;
    for (int k = 0; k < NBYTES; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_a_byte = r_a[k*BYTE_W +: BYTE_W];
        w_b_byte = r_b[k*BYTE_W +: BYTE_W];
      end
    end
  end

  byte_adder u_byte_adder (
    .i_a    (w_a_byte),
    .i_b    (w_b_byte),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout)
  );

  // NOTE: operand registers carry no reset; they are always loaded on accept before being read.
  always_ff @(posedge clk) begin
    if (!rst && w_accept) begin
      r_a <= a;
      r_b <= b;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_carry <= cin;
            r_idx   <= '0;
            r_state <= ADD;
          end
        end
        ADD: begin
          for (int k = 0; k < NBYTES; k++) begin
            if (r_idx == IDX_W'(k)) r_sum[k*BYTE_W +: BYTE_W] <= w_slice_sum;
          end
          r_carry <= w_slice_cout;
          if (w_last) begin
            // Top-slice carry leaves through cout only; it never wraps to byte 0.
            r_cout      <= w_slice_cout;
            r_ovf       <= (r_a[W-1] == r_b[W-1]) & (w_slice_sum[BYTE_W-1] != r_a[W-1]);
            r_out_valid <= 1'b1;
            r_idx       <= '0;
            r_state     <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
